countdown_timer: RTL and testbench

Loadable down-counter timer: the decrementing counterpart to the team's step/overwrite up-counter. A host loads a start value over a valid/ready handshake. The block counts down to zero at a programmable tick rate and emits a one-cycle expiry pulse at zero. It can optionally reload and repeat. It sits beside the up-counter in the datapath as the timeout/interval source for sequencing logic.

---
 rtl/counter_pkg.sv | 13 +
 rtl/tick_gen.sv | 39 +++
 rtl/countdown_timer.sv | 119 +++++++++++
 tb/tb_countdown_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up-counter and countdown timer):
// FSM state encoding and default widths.
package counter_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_PRESCALE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : counter_pkg

// File: rtl/tick_gen.sv
// Prescaler: raises tick while its count equals the latched prescale value,
// then wraps to zero, giving one tick every prescale+1 enabled cycles.
module tick_gen #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  hold,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == prescale);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen

// File: rtl/countdown_timer.sv
// Loadable down-counter timer: accepts a start value over valid/ready, counts
// down at a prescaled rate and pulses expire on reaching zero, optionally reloading.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [WIDTH-1:0]      reload_q, reload_d;
  logic                  auto_q, auto_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  expire_q, expire_d;
  logic                  busy_q;
  logic                  tick;
  logic                  accept;

  assign load_ready = (state_q == IDLE);
  assign accept     = load_valid && load_ready;

  // The prescaler sits at zero outside RUN, so every accept starts a fresh period.
  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state_q != RUN) || abort),
    .hold    (pause),
    .prescale(prescale_q),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    auto_d     = auto_q;
    prescale_d = prescale_q;
    expire_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          count_d    = load_value;
          reload_d   = load_value;
          auto_d     = auto_reload;
          prescale_d = prescale;
          if (load_value != '0) begin
            state_d = RUN;
          end else begin
            expire_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (!pause && tick) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            // RUN never holds zero, so this is the 1 -> 0 (or reload) step.
            expire_d = 1'b1;
            if (auto_q) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      auto_q     <= 1'b0;
      prescale_q <= '0;
      expire_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      auto_q     <= auto_d;
      prescale_q <= prescale_d;
      expire_q   <= expire_d;
      busy_q     <= (state_d == RUN);
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign expire = expire_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected per-cycle state
// and expiry cycles; a monitor on the falling edge pops and compares them.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       auto_reload;
  logic [3:0] prescale;
  logic       pause;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       expire;

  countdown_timer #(
    .WIDTH(8),
    .PRESCALE_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .expire     (expire)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] count;
    logic       busy;
    logic       expire;
    logic       ready;
    string      name;
  } exp_t;

  exp_t tq[$];
  int   eq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_at(input int c, input logic [7:0] cnt, input logic b,
                           input logic e, input logic r, input string name);
    exp_t x;
    x.cyc = c; x.count = cnt; x.busy = b; x.expire = e; x.ready = r; x.name = name;
    tq.push_back(x);
  endtask

  // Monitor: compares every queued entry due this cycle, and matches each
  // observed expire pulse against the expected expiry cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = tq.size() - 1; i >= 0; i--) begin
        if (tq[i].cyc == cyc) begin
          check({tq[i].name, ".count"},  32'(count),      32'(tq[i].count));
          check({tq[i].name, ".busy"},   32'(busy),       32'(tq[i].busy));
          check({tq[i].name, ".expire"}, 32'(expire),     32'(tq[i].expire));
          check({tq[i].name, ".ready"},  32'(load_ready), 32'(tq[i].ready));
          tq.delete(i);
        end else if (tq[i].cyc < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: entry for cyc %0d never sampled (now %0d)", tq[i].name, tq[i].cyc, cyc);
          tq.delete(i);
        end
      end
      if (expire) begin
        if (eq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_expire: got expire=1 at cyc %0d, expected none", cyc);
        end else begin
          check("expire_cycle", 32'(cyc), 32'(eq.pop_front()));
        end
      end else begin
        while (eq.size() != 0 && eq[0] <= cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL missing_expire: got no expire at cyc %0d, expected one", eq.pop_front());
        end
      end
    end
  end

  task automatic load_start(input logic [7:0] v, input logic [3:0] p, input logic ar,
                            output int e0);
    @(negedge clk);
    load_valid  = 1'b1;
    load_value  = v;
    prescale    = p;
    auto_reload = ar;
    e0          = cyc + 1;
  endtask

  task automatic load_end();
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    rst_n       = 1'b0;
    load_valid  = 1'b0;
    load_value  = '0;
    auto_reload = 1'b0;
    prescale    = '0;
    pause       = 1'b0;
    abort       = 1'b0;

    // Power-on reset values.
    repeat (2) @(negedge clk);
    check("por.count", 32'(count), 0);
    check("por.busy", 32'(busy), 0);
    check("por.expire", 32'(expire), 0);
    check("por.ready", 32'(load_ready), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-RUN with count parked at 5 by a slow prescale.
    load_start(8'd5, 4'd15, 1'b0, e0);
    expect_at(e0, 8'd5, 1'b1, 1'b0, 1'b0, "rst_run");
    load_end();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 0);
    check("async_rst.busy", 32'(busy), 0);
    check("async_rst.expire", 32'(expire), 0);
    check("async_rst.ready", 32'(load_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One-shot N=3, P=0.
    load_start(8'd3, 4'd0, 1'b0, e0);
    expect_at(e0,     8'd3, 1'b1, 1'b0, 1'b0, "oneshot0");
    expect_at(e0 + 1, 8'd2, 1'b1, 1'b0, 1'b0, "oneshot1");
    expect_at(e0 + 2, 8'd1, 1'b1, 1'b0, 1'b0, "oneshot2");
    expect_at(e0 + 3, 8'd0, 1'b0, 1'b1, 1'b1, "oneshot3");
    expect_at(e0 + 4, 8'd0, 1'b0, 1'b0, 1'b1, "oneshot4");
    eq.push_back(e0 + 3);
    load_end();
    repeat (6) @(negedge clk);

    // Auto-reload N=2, P=2: period 6, three periods, then abort.
    load_start(8'd2, 4'd2, 1'b1, e0);
    for (int j = 0; j <= 18; j++) begin
      expect_at(e0 + j, ((j % 6) < 3) ? 8'd2 : 8'd1, 1'b1,
                (j > 0 && (j % 6) == 0), 1'b0, "reload");
    end
    eq.push_back(e0 + 6);
    eq.push_back(e0 + 12);
    eq.push_back(e0 + 18);
    load_end();
    repeat (18) @(negedge clk);
    abort = 1'b1;
    expect_at(e0 + 19, 8'd0, 1'b0, 1'b0, 1'b1, "reload_abort");
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);

    // Pause for three cycles after the first decrement: expiry slips by three.
    load_start(8'd4, 4'd0, 1'b0, e0);
    expect_at(e0, 8'd4, 1'b1, 1'b0, 1'b0, "pause0");
    for (int j = 1; j <= 4; j++) expect_at(e0 + j, 8'd3, 1'b1, 1'b0, 1'b0, "pause_hold");
    expect_at(e0 + 5, 8'd2, 1'b1, 1'b0, 1'b0, "pause5");
    expect_at(e0 + 6, 8'd1, 1'b1, 1'b0, 1'b0, "pause6");
    expect_at(e0 + 7, 8'd0, 1'b0, 1'b1, 1'b1, "pause7");
    eq.push_back(e0 + 7);
    load_end();
    @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    repeat (6) @(negedge clk);

    // Abort on the same edge as the final tick: no expire.
    load_start(8'd1, 4'd0, 1'b0, e0);
    expect_at(e0,     8'd1, 1'b1, 1'b0, 1'b0, "abort_run");
    expect_at(e0 + 1, 8'd0, 1'b0, 1'b0, 1'b1, "abort_idle");
    expect_at(e0 + 2, 8'd0, 1'b0, 1'b0, 1'b1, "abort_idle2");
    load_end();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);

    // Load value 0: immediate expire, stays IDLE.
    load_start(8'd0, 4'd0, 1'b0, e0);
    expect_at(e0,     8'd0, 1'b0, 1'b1, 1'b1, "zero_load");
    expect_at(e0 + 1, 8'd0, 1'b0, 1'b0, 1'b1, "zero_after");
    eq.push_back(e0);
    load_end();
    repeat (2) @(negedge clk);

    // Load held during RUN is accepted on the first IDLE edge.
    load_start(8'd2, 4'd0, 1'b0, e0);
    expect_at(e0,      8'd2, 1'b1, 1'b0, 1'b0, "held0");
    expect_at(e0 + 1,  8'd1, 1'b1, 1'b0, 1'b0, "held_ignored");
    expect_at(e0 + 2,  8'd0, 1'b0, 1'b1, 1'b1, "held_expire");
    expect_at(e0 + 3,  8'd7, 1'b1, 1'b0, 1'b0, "held_accept");
    expect_at(e0 + 9,  8'd1, 1'b1, 1'b0, 1'b0, "held_last");
    expect_at(e0 + 10, 8'd0, 1'b0, 1'b1, 1'b1, "held_done");
    eq.push_back(e0 + 2);
    eq.push_back(e0 + 10);
    load_end();
    load_valid = 1'b1;
    load_value = 8'd7;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    repeat (10) @(negedge clk);

    check("trace_queue_drained", 32'(tq.size()), 0);
    check("expire_queue_drained", 32'(eq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_countdown_timer
